// File: rtl/alu_exmem_stage.sv
// EX/MEM stage: two-entry skid buffer behind the ALU,
// turns trapping signed overflow into a precise exception.
module alu_exmem_stage #(
  parameter int          N      = 32,
  parameter logic [4:0]  EXC_OV = 5'd12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ALUResult,
  input  logic         ALUZero,
  input  logic         ALUOverflow,
  input  logic         in_trap_en,
  input  logic [N-1:0] in_pc,
  input  logic [4:0]   in_wreg,
  input  logic         in_regwrite,
  input  logic         in_memread,
  input  logic         in_memwrite,
  input  logic [N-1:0] in_wdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_zero,
  output logic [N-1:0] out_pc,
  output logic [4:0]   out_wreg,
  output logic [N-1:0] out_wdata,
  output logic         out_regwrite,
  output logic         out_memread,
  output logic         out_memwrite,
  input  logic         flush,
  output logic         exc_valid,
  output logic [N-1:0] exc_epc,
  output logic [4:0]   exc_cause,
  input  logic         exc_ack
);

  typedef struct packed {
    logic [N-1:0] result;
    logic         zero;
    logic [N-1:0] pc;
    logic [4:0]   wreg;
    logic [N-1:0] wdata;
    logic         rw;
    logic         mr;
    logic         mw;
  } ent_t;

  typedef enum logic {RUN, TRAP} state_e;

  ent_t         main_q, main_d;
  ent_t         skid_q, skid_d;
  ent_t         in_ent;
  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  state_e       state_q, state_d;
  logic         exc_v_q, exc_v_d;
  logic [N-1:0] epc_q, epc_d;
  logic [4:0]   cause_q, cause_d;
  logic         rdy_q, rdy_d;
  logic         acc;
  logic         drain;
  logic         ovf;
  logic         trap;

  // ready is held low while reset is asserted
  assign in_ready = rdy_q & ~reset;
  assign acc      = in_valid & in_ready;
  assign drain    = main_v_q & out_ready;
  assign ovf      = ALUOverflow & in_trap_en;
  assign trap     = acc & ovf & ~flush;

  always_comb begin
    in_ent        = '0;
    in_ent.result = ALUResult;
    in_ent.zero   = ALUZero;
    in_ent.pc     = in_pc;
    in_ent.wreg   = in_wreg;
    in_ent.wdata  = in_wdata;
    in_ent.rw     = in_regwrite & ~ovf;
    in_ent.mr     = in_memread & ~ovf;
    in_ent.mw     = in_memwrite & ~ovf;
  end

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    state_d  = state_q;
    exc_v_d  = 1'b0;
    epc_d    = epc_q;
    cause_d  = cause_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      state_d  = RUN;
    end else begin
      if (drain && skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_d   = in_ent;
        skid_v_d = acc;
      end else if (!main_v_q || drain) begin
        main_d   = in_ent;
        main_v_d = acc;
      end else if (acc) begin
        skid_d   = in_ent;
        skid_v_d = 1'b1;
      end
      case (state_q)
        RUN: begin
          if (trap) begin
            state_d = TRAP;
            exc_v_d = 1'b1;
            epc_d   = in_pc;
            cause_d = EXC_OV;
          end
        end
        TRAP: begin
          if (exc_ack) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    rdy_d = ~skid_v_d & (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      state_q  <= RUN;
      exc_v_q  <= 1'b0;
      epc_q    <= '0;
      cause_q  <= '0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      state_q  <= state_d;
      exc_v_q  <= exc_v_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      rdy_q    <= rdy_d;
    end
  end

  assign out_valid    = main_v_q;
  assign out_result   = main_q.result;
  assign out_zero     = main_q.zero;
  assign out_pc       = main_q.pc;
  assign out_wreg     = main_q.wreg;
  assign out_wdata    = main_q.wdata;
  assign out_regwrite = main_v_q & main_q.rw;
  assign out_memread  = main_v_q & main_q.mr;
  assign out_memwrite = main_v_q & main_q.mw;
  assign exc_valid    = exc_v_q;
  assign exc_epc      = epc_q;
  assign exc_cause    = cause_q;

endmodule

// File: tb/tb_alu_exmem_stage.sv
// Bench for alu_exmem_stage: queue model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_alu_exmem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] ALUResult = '0;
  logic        ALUZero = 1'b0;
  logic        ALUOverflow = 1'b0;
  logic        in_trap_en = 1'b0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_wreg = '0;
  logic        in_regwrite = 1'b0;
  logic        in_memread = 1'b0;
  logic        in_memwrite = 1'b0;
  logic [31:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic [31:0] out_pc;
  logic [4:0]  out_wreg;
  logic [31:0] out_wdata;
  logic        out_regwrite;
  logic        out_memread;
  logic        out_memwrite;
  logic        flush = 1'b0;
  logic        exc_valid;
  logic [31:0] exc_epc;
  logic [4:0]  exc_cause;
  logic        exc_ack = 1'b0;

  always #5 clk = ~clk;

  alu_exmem_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .ALUZero(ALUZero),
    .ALUOverflow(ALUOverflow), .in_trap_en(in_trap_en),
    .in_pc(in_pc), .in_wreg(in_wreg),
    .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_pc(out_pc), .out_wreg(out_wreg),
    .out_wdata(out_wdata), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite),
    .flush(flush), .exc_valid(exc_valid),
    .exc_epc(exc_epc), .exc_cause(exc_cause),
    .exc_ack(exc_ack)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic [31:0] wd;
    logic        rw;
    logic        mr;
    logic        mw;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  bit          started = 0;
  bit          m_trap = 0;
  bit          m_excv = 0;
  bit          m_rdy = 0;
  bit          macc;
  bit          mov;
  logic [31:0] m_epc = '0;
  logic [4:0]  m_cause = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: held entries as a FIFO of at most two
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_trap  = 0;
      m_excv  = 0;
      m_epc   = '0;
      m_cause = '0;
      m_rdy   = 1;
      started = 1;
    end else if (started) begin
      macc = in_valid && m_rdy;
      if (flush) begin
        q.delete();
        m_trap = 0;
        m_excv = 0;
      end else begin
        mov = ALUOverflow && in_trap_en;
        if (q.size() > 0 && out_ready) q.delete(0);
        if (macc) begin
          e.res  = ALUResult;
          e.z    = ALUZero;
          e.pc   = in_pc;
          e.wreg = in_wreg;
          e.wd   = in_wdata;
          e.rw   = in_regwrite && !mov;
          e.mr   = in_memread && !mov;
          e.mw   = in_memwrite && !mov;
          q.push_back(e);
        end
        m_excv = macc && mov;
        if (m_excv) begin
          m_trap  = 1;
          m_epc   = in_pc;
          m_cause = 5'd12;
        end else if (m_trap && exc_ack) begin
          m_trap = 0;
        end
      end
      m_rdy = (q.size() < 2) && !m_trap;
    end
    if (started) begin
      #1;
      chk("m_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("m_result", out_result, q[0].res);
        chk("m_zero", out_zero, q[0].z);
        chk("m_pc", out_pc, q[0].pc);
        chk("m_wreg", out_wreg, q[0].wreg);
        chk("m_wdata", out_wdata, q[0].wd);
        chk("m_ctrl", {out_regwrite, out_memread, out_memwrite},
            {q[0].rw, q[0].mr, q[0].mw});
      end else begin
        chk("m_ctrl_idle", {out_regwrite, out_memread, out_memwrite}, 0);
      end
      chk("m_in_ready", in_ready, m_rdy && !reset);
      chk("m_exc_valid", exc_valid, m_excv && !reset);
      chk("m_exc_epc", exc_epc, m_epc);
      chk("m_exc_cause", exc_cause, m_cause);
    end
  end

  task automatic drv(input bit v, input logic [31:0] res,
                     input logic [31:0] pc, input bit ov,
                     input bit te, input bit ordy);
    in_valid    = v;
    ALUResult   = res;
    ALUZero     = (res == 0);
    ALUOverflow = ov;
    in_trap_en  = te;
    in_pc       = pc;
    in_wreg     = pc[6:2];
    in_regwrite = 1'b1;
    in_memread  = 1'b0;
    in_memwrite = res[0];
    in_wdata    = ~res;
    out_ready   = ordy;
    flush       = 1'b0;
    exc_ack     = 1'b0;
  endtask

  task automatic idle(input bit ordy);
    drv(0, 32'h0, 32'h0, 0, 0, ordy);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle(0);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_exc_epc", exc_epc, 0);
    chk("rst_in_ready_low", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready_high", in_ready, 1);

    // Stream of 8 at full throughput
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drv(1, 32'h1000 + i, 32'h00400000 + 4 * i, 0, 0, 1);
      tick();
      chk("stream_result", out_result, 32'h1000 + i);
      chk("stream_ready", in_ready, 1);
    end
    @(negedge clk);
    idle(1);
    tick();
    chk("stream_empty", out_valid, 0);

    // Backpressure: two held, third refused
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(1, 32'h2000 + i, 32'h00401000 + 4 * i, 0, 0, 0);
      tick();
      chk("bp_head", out_result, 32'h2000);
      if (i > 0) chk("bp_ready_low", in_ready, 0);
    end
    @(negedge clk);
    idle(1);
    tick();
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second", out_result, 32'h2001);
    @(negedge clk);
    tick();
    chk("bp_drained", out_valid, 0);

    // Trapping overflow
    @(negedge clk);
    drv(1, 32'h80000000, 32'h00400010, 1, 1, 1);
    tick();
    chk("trap_valid", out_valid, 1);
    chk("trap_regwrite", out_regwrite, 0);
    chk("trap_exc_valid", exc_valid, 1);
    chk("trap_epc", exc_epc, 32'h00400010);
    chk("trap_cause", exc_cause, 12);
    chk("trap_ready", in_ready, 0);
    @(negedge clk);
    drv(1, 32'h5, 32'h00400014, 0, 0, 1);
    tick();
    chk("trap_pulse_end", exc_valid, 0);
    chk("trap_hold_ready", in_ready, 0);
    chk("trap_no_accept", out_valid, 0);
    @(negedge clk);
    idle(1);
    exc_ack = 1'b1;
    tick();
    chk("ack_ready", in_ready, 1);

    // Non-trapping overflow
    @(negedge clk);
    drv(1, 32'h80000000, 32'h00400020, 1, 0, 1);
    tick();
    chk("notrap_regwrite", out_regwrite, 1);
    chk("notrap_result", out_result, 32'h80000000);
    chk("notrap_exc", exc_valid, 0);
    chk("notrap_ready", in_ready, 1);
    @(negedge clk);
    idle(1);
    tick();

    // Flush with both entries full
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drv(1, 32'h3000 + i, 32'h00402000 + 4 * i, 0, 0, 0);
      tick();
    end
    @(negedge clk);
    drv(1, 32'h7fffffff, 32'hdead0000, 1, 1, 0);
    flush = 1'b1;
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_exc", exc_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_epc", exc_epc, 32'h00400010);
    @(negedge clk);
    drv(1, 32'h7fffffff, 32'hdead0004, 1, 1, 1);
    flush = 1'b1;
    tick();
    chk("flush_acc_valid", out_valid, 0);
    chk("flush_acc_exc", exc_valid, 0);
    chk("flush_acc_epc", exc_epc, 32'h00400010);

    // Reset mid-stall
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drv(1, 32'h4000 + i, 32'h00403000 + 4 * i, 0, 0, 0);
      tick();
    end
    @(negedge clk);
    idle(0);
    reset = 1'b1;
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_result", out_result, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_regwrite", out_regwrite, 0);
    chk("mrst_epc", exc_epc, 0);
    chk("mrst_cause", exc_cause, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_ready", in_ready, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drv($urandom_range(0, 9) < 7, $urandom,
          $urandom, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
      in_regwrite = $urandom_range(0, 1) == 1;
      in_memread  = $urandom_range(0, 1) == 1;
      in_wreg     = 5'($urandom);
      exc_ack     = $urandom_range(0, 3) == 0;
      flush       = $urandom_range(0, 49) == 0;
      reset       = $urandom_range(0, 199) == 0;
    end
    @(negedge clk);
    idle(1);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
